// File: rtl/pkt_chk32_pkg.sv
// Shared types and constants for the pkt_chk32 framing checker.
// Error codes, FSM encoding and packer FIFO bus field offsets.
package pkt_chk32_pkg;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_MISSING_EOP = 3'd1;
  localparam logic [2:0] ERR_DATA_NO_SOP = 3'd2;
  localparam logic [2:0] ERR_MTY_NOT_EOP = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG    = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } state_t;

  localparam int BUS_W      = 36;
  localparam int BUS_SOP    = 35;
  localparam int BUS_EOP    = 34;
  localparam int BUS_MTY_HI = 33;
  localparam int BUS_MTY_LO = 32;

endpackage

// File: rtl/stat_cnt.sv
// Wrapping statistics counter.
// Synchronous clear takes priority over increment.
module stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pkt_chk32.sv
// Framing checker and byte-length extractor for the 32-bit packet bus.
// One beat per cycle, registered outputs, wrap-around statistics.
module pkt_chk32
  import pkt_chk32_pkg::*;
#(
  parameter int          LEN_W   = 16,
  parameter int          CNT_W   = 16,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      din,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic [1:0]       din_mty,
  input  logic             din_vld,
  input  logic             stat_clr,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_len_vld,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [BUS_W-1:0] beat;
  logic             sop;
  logic             eop;
  logic [1:0]       mty;
  logic             unused_data;

  assign beat = {din_sop, din_eop, din_mty, din};
  assign sop  = beat[BUS_SOP];
  assign eop  = beat[BUS_EOP];
  assign mty  = beat[BUS_MTY_HI:BUS_MTY_LO];
  assign unused_data = ^beat[31:0];

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] acc;
  logic [LEN_W-1:0] acc_n;
  logic [LEN_W-1:0] base;
  logic [LEN_W-1:0] sat;
  logic [LEN_W:0]   sum;
  logic [2:0]       add;
  logic             done;
  logic             e1, e2, e3, e4;
  logic [LEN_W-1:0] len_n;
  logic             vld_n;
  logic             err_n;
  logic [2:0]       code_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    done    = 1'b0;
    e1      = 1'b0;
    e2      = 1'b0;
    e3      = 1'b0;
    e4      = 1'b0;
    add     = 3'd4;
    base    = '0;
    sum     = '0;
    sat     = '0;
    if (din_vld) begin
      e3   = !eop && (mty != 2'd0);
      add  = eop ? 3'd4 - {1'b0, mty} : 3'd4;
      // a sop beat always starts counting from zero
      base = (state == S_IN_PKT && !sop) ? acc : '0;
      sum  = {1'b0, base} + (LEN_W+1)'(add);
      sat  = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
      if (state == S_IDLE && !sop) begin
        e2 = 1'b1;
      end else begin
        e1 = (state == S_IN_PKT) && sop;
        if (eop) begin
          done    = 1'b1;
          state_n = S_IDLE;
          acc_n   = '0;
        end else begin
          state_n = S_IN_PKT;
          acc_n   = sat;
        end
      end
      e4 = done && (32'(sat) > MAX_LEN);
    end
  end

  always_comb begin
    vld_n  = done && !e4;
    len_n  = vld_n ? sat : pkt_len;
    err_n  = e1 | e2 | e3 | e4;
    code_n = ERR_NONE;
    priority case (1'b1)
      e2:      code_n = ERR_DATA_NO_SOP;
      e1:      code_n = ERR_MISSING_EOP;
      e3:      code_n = ERR_MTY_NOT_EOP;
      e4:      code_n = ERR_TOO_LONG;
      default: code_n = ERR_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_len     <= '0;
      pkt_len_vld <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      pkt_len     <= len_n;
      pkt_len_vld <= vld_n;
      err         <= err_n;
      err_code    <= code_n;
    end
  end

  stat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (pkt_len_vld),
    .cnt   (pkt_cnt)
  );

  stat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (err),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_pkt_chk32.sv
// Self-checking bench for pkt_chk32: directed cases plus random traffic.
// Packet-level reference model compared against the DUT every cycle.
module tb_pkt_chk32;

  localparam int LEN_W = 16;
  localparam int CNT_W = 8;
  localparam int MAXL  = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      din = '0;
  logic             din_sop = 1'b0;
  logic             din_eop = 1'b0;
  logic [1:0]       din_mty = '0;
  logic             din_vld = 1'b0;
  logic             stat_clr = 1'b0;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_len_vld;
  logic             err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  pkt_chk32 #(.LEN_W(LEN_W), .CNT_W(CNT_W), .MAX_LEN(MAXL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_sop     (din_sop),
    .din_eop     (din_eop),
    .din_mty     (din_mty),
    .din_vld     (din_vld),
    .stat_clr    (stat_clr),
    .pkt_len     (pkt_len),
    .pkt_len_vld (pkt_len_vld),
    .err         (err),
    .err_code    (err_code),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit m_in;
  int m_bytes;
  int nxt_len, nxt_code;
  bit nxt_vld, nxt_err, nxt_clr;
  int exp_len, exp_code, exp_pc, exp_ec;
  bit exp_vld, exp_err;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pkt_len", int'(pkt_len), exp_len);
      cmp("pkt_len_vld", int'(pkt_len_vld), int'(exp_vld));
      cmp("err", int'(err), int'(exp_err));
      cmp("err_code", int'(err_code), exp_code);
      cmp("pkt_cnt", int'(pkt_cnt), exp_pc);
      cmp("err_cnt", int'(err_cnt), exp_ec);
    end
  end

  task automatic model_reset();
    m_in = 0; m_bytes = 0;
    exp_len = 0; exp_vld = 0; exp_err = 0;
    exp_code = 0; exp_pc = 0; exp_ec = 0;
  endtask

  // Packet-level rules: what the outputs must be after this beat
  task automatic model_eval(input bit s, e, input int m, input bit v);
    bit e1, e2, e3, e4, complete;
    int len;
    e1 = 0; e2 = 0; e3 = 0; e4 = 0; complete = 0; len = 0;
    if (v) begin
      e3 = !e && m != 0;
      if (!m_in && !s) begin
        e2 = 1;
      end else begin
        e1 = m_in && s;
        if (s) m_bytes = 0;
        m_bytes = m_bytes + (e ? 4 - m : 4);
        if (m_bytes > 65535) m_bytes = 65535;
        if (e) begin
          complete = 1; len = m_bytes; m_in = 0; m_bytes = 0;
        end else begin
          m_in = 1;
        end
      end
      e4 = complete && len > MAXL;
    end
    nxt_vld = complete && !e4;
    nxt_len = len;
    nxt_err = e1 | e2 | e3 | e4;
    nxt_code = e2 ? 2 : e1 ? 1 : e3 ? 3 : e4 ? 4 : 0;
  endtask

  task automatic model_commit();
    exp_pc = nxt_clr ? 0 : (exp_pc + int'(exp_vld)) % (1 << CNT_W);
    exp_ec = nxt_clr ? 0 : (exp_ec + int'(exp_err)) % (1 << CNT_W);
    if (nxt_vld) exp_len = nxt_len;
    exp_vld = nxt_vld;
    exp_err = nxt_err;
    exp_code = nxt_code;
  endtask

  task automatic step(input bit s, e, input logic [1:0] m, input bit v, c);
    @(negedge clk);
    din = $urandom;
    din_sop = s; din_eop = e; din_mty = m;
    din_vld = v; stat_clr = c;
    nxt_clr = c;
    model_eval(s, e, int'(m), v);
    @(posedge clk);
    #1;
    model_commit();
    din_vld = 1'b0; stat_clr = 1'b0;
    din_sop = 1'b0; din_eop = 1'b0; din_mty = '0;
  endtask

  task automatic bt(input bit s, e, input logic [1:0] m);
    step(s, e, m, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst_n = 1'b0;
    din_vld = 1'b0; stat_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    bit s, e, c, v;
    logic [1:0] m;
    model_reset();
    do_reset();
    #1;
    cmp("rst_pkt_len", int'(pkt_len), 0);
    cmp("rst_err", int'(err), 0);
    cmp("rst_pkt_cnt", int'(pkt_cnt), 0);

    bt(1, 0, 0); bt(0, 0, 0); bt(0, 1, 2);
    cmp("len10_vld", int'(pkt_len_vld), 1);
    cmp("len10", int'(pkt_len), 10);
    cmp("len10_err", int'(err), 0);
    idle();
    cmp("len10_cnt", int'(pkt_cnt), 1);

    bt(1, 1, 3);
    cmp("len1", int'(pkt_len), 1);
    bt(1, 0, 0); bt(0, 1, 0);
    cmp("len8_b2b", int'(pkt_len), 8);
    idle();
    cmp("b2b_cnt", int'(pkt_cnt), 3);

    step(0, 0, 0, 0, 1);
    bt(1, 0, 0); bt(0, 0, 0); bt(1, 0, 0);
    cmp("abort_code", int'(err_code), 1);
    cmp("abort_vld", int'(pkt_len_vld), 0);
    bt(0, 1, 0);
    cmp("restart_len", int'(pkt_len), 8);
    bt(1, 0, 0); bt(1, 1, 0);
    cmp("abort1w_code", int'(err_code), 1);
    cmp("abort1w_vld", int'(pkt_len_vld), 1);
    cmp("abort1w_len", int'(pkt_len), 4);
    idle();
    cmp("abort_pcnt", int'(pkt_cnt), 2);
    cmp("abort_ecnt", int'(err_cnt), 2);

    bt(0, 0, 0);
    cmp("nosop_code", int'(err_code), 2);
    cmp("nosop_vld", int'(pkt_len_vld), 0);
    bt(1, 0, 0); bt(0, 0, 1);
    cmp("mty_code", int'(err_code), 3);
    bt(0, 1, 0);
    cmp("mty_len", int'(pkt_len), 12);

    bt(1, 0, 0);
    for (int i = 0; i < 15; i++) bt(0, 0, 0);
    bt(0, 1, 0);
    cmp("long_code", int'(err_code), 4);
    cmp("long_vld", int'(pkt_len_vld), 0);
    step(0, 0, 0, 0, 1);
    cmp("clr_pcnt", int'(pkt_cnt), 0);
    cmp("clr_ecnt", int'(err_cnt), 0);
    bt(1, 0, 0);
    for (int i = 0; i < 14; i++) bt(0, 0, 0);
    bt(0, 1, 0);
    cmp("max_vld", int'(pkt_len_vld), 1);
    cmp("max_len", int'(pkt_len), 64);

    bt(1, 0, 0); bt(0, 0, 0);
    do_reset();
    bt(1, 1, 0);
    cmp("rst_mid_len", int'(pkt_len), 4);
    cmp("rst_mid_err", int'(err), 0);

    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      s = m_in ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
      e = ($urandom_range(0, 9) == 0);
      if (e) m = 2'($urandom_range(0, 3));
      else m = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      c = ($urandom_range(0, 299) == 0);
      step(s, e, m, v, c);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
